// File: rtl/stack_ptr_unit.sv
// stack_ptr_unit: parametrised stack-pointer register with programmable
// lower/upper bounds, signed frame adjust and sticky ovf/unf flags. Any
// rejected inc/dec/adj moves the unit into a FAULT lock-out state, which
// only clr_flt (or reset) leaves. The pointer drives the address and data
// buses through tri-state outputs.
//
// Optional feature, enabled by defining SP_HWM_EN: a low-water-mark
// register (hwm) that tracks the deepest pointer value reached. Because
// the stack grows downward, this is the minimum pointer value. The
// feature adds the read_hwm and clr_hwm inputs.
module stack_ptr_unit #(
    parameter int              WIDTH    = 16,
    parameter int              STEP     = 1,
    parameter logic [WIDTH-1:0] RESET_SP = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             write,
    input  logic             adj,
    input  logic             inc,
    input  logic             dec,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic             clr_flt,
    input  logic             read_abus,
    input  logic             read_dbus,
`ifdef SP_HWM_EN
    input  logic             read_hwm,
    input  logic             clr_hwm,
`endif
    output logic [WIDTH-1:0] abus_out,
    output logic [WIDTH-1:0] dbus_out,
    output logic             ovf,
    output logic             unf,
    output logic             fault
);

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    // Step amount widened to the candidate width.
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    state_t           state;
    logic [WIDTH-1:0] sp;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    logic             arith_req;   // adj, inc or dec requested
    logic             arith_up;    // a rejection of this op sets ovf (else unf)
    logic [WIDTH:0]   cand;        // candidate pointer, extra bit catches carry/borrow
    logic             in_range;
    logic             op_enable;
    logic             do_write;
    logic             do_arith;
    logic             accept;
    logic             reject;
    logic             sp_upd;
    logic [WIDTH-1:0] sp_next;

    // Select the highest-priority arithmetic op and form its candidate.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        arith_req = 1'b0;
        arith_up  = 1'b0;
        cand      = {1'b0, sp};
        if (adj) begin
            arith_req = 1'b1;
            arith_up  = ~din[WIDTH-1];
            cand      = {1'b0, sp} + {din[WIDTH-1], din};
        end else if (inc) begin
            arith_req = 1'b1;
            arith_up  = 1'b1;
            cand      = {1'b0, sp} + STEP_EXT;
        end else if (dec) begin
            arith_req = 1'b1;
            arith_up  = 1'b0;
            cand      = {1'b0, sp} - STEP_EXT;
        end
    end

    // Range check against the bounds as they stand before this edge.
    // A set top bit means carry or borrow, which is always out of range.
    assign in_range = ~cand[WIDTH] && (cand[WIDTH-1:0] >= lo) && (cand[WIDTH-1:0] <= hi);

    // Pointer ops run only in RUN, and clr_flt swallows any op in its cycle.
    assign op_enable = (state == ST_RUN) && !clr_flt;
    assign do_write  = op_enable && write;
    assign do_arith  = op_enable && !write && arith_req;
    assign accept    = do_arith && in_range;
    assign reject    = do_arith && !in_range;
    assign sp_upd    = do_write || accept;
    assign sp_next   = do_write ? din : (accept ? cand[WIDTH-1:0] : sp);

    // Pointer, bounds, sticky flags and the RUN/FAULT state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= RESET_SP;
            lo    <= '0;
            hi    <= '1;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            fault <= 1'b0;
            state <= ST_RUN;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values, matching the hardware.
            sp <= sp_next;
            if (wr_lo) lo <= din;
            if (wr_hi) hi <= din;
            if (clr_flt) begin
                ovf   <= 1'b0;
                unf   <= 1'b0;
                fault <= 1'b0;
                state <= ST_RUN;
            end else if (reject) begin
                if (arith_up) ovf <= 1'b1;
                else          unf <= 1'b1;
                fault <= 1'b1;
                state <= ST_FAULT;
            end
        end
    end

    // Address bus carries the pointer whenever it is strobed.
    assign abus_out = read_abus ? sp : {WIDTH{1'bz}};

`ifdef SP_HWM_EN
    logic [WIDTH-1:0] hwm;

    // Track the lowest pointer value; clr_hwm restarts tracking from the
    // pointer value as it will be after this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hwm <= RESET_SP;
        end else if (clr_hwm) begin
            hwm <= sp_next;
        end else if (sp_upd && (sp_next < hwm)) begin
            hwm <= sp_next;
        end
    end

    // Data bus: the watermark read takes precedence over the pointer read.
    assign dbus_out = read_hwm  ? hwm :
                      read_dbus ? sp  : {WIDTH{1'bz}};
`else
    // Data bus carries the pointer whenever it is strobed.
    assign dbus_out = read_dbus ? sp : {WIDTH{1'bz}};

    // sp_upd only feeds the watermark logic.
    logic unused_sp_upd;
    assign unused_sp_upd = sp_upd;
`endif

endmodule

// File: tb/tb_stack_ptr_unit.sv
// tb_stack_ptr_unit: directed checks with literal expectations, followed by
// randomized stimulus compared on every cycle against an integer-arithmetic
// model of the stack pointer, its bounds, flags and lock-out state.
module tb_stack_ptr_unit;

    localparam int              W    = 16;
    localparam int              STEP = 1;
    localparam logic [W-1:0]    RSP  = 16'h0000;

    // Op mask bits for the cyc() helper.
    localparam logic [7:0] OP_WR   = 8'h01;
    localparam logic [7:0] OP_ADJ  = 8'h02;
    localparam logic [7:0] OP_INC  = 8'h04;
    localparam logic [7:0] OP_DEC  = 8'h08;
    localparam logic [7:0] OP_LO   = 8'h10;
    localparam logic [7:0] OP_HI   = 8'h20;
    localparam logic [7:0] OP_CLR  = 8'h40;
    localparam logic [7:0] OP_CLRH = 8'h80;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         write, adj, inc, dec, wr_lo, wr_hi, clr_flt;
    logic         read_abus, read_dbus;
    logic         read_hwm, clr_hwm;
    tri1  [W-1:0] abus;   // pulled up: an undriven bus reads all ones
    tri1  [W-1:0] dbus;
    logic         ovf, unf, fault;

    int vectors     = 0;
    int miscompares = 0;

    stack_ptr_unit #(.WIDTH(W), .STEP(STEP), .RESET_SP(RSP)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .write     (write),
        .adj       (adj),
        .inc       (inc),
        .dec       (dec),
        .wr_lo     (wr_lo),
        .wr_hi     (wr_hi),
        .clr_flt   (clr_flt),
        .read_abus (read_abus),
        .read_dbus (read_dbus),
`ifdef SP_HWM_EN
        .read_hwm  (read_hwm),
        .clr_hwm   (clr_hwm),
`endif
        .abus_out  (abus),
        .dbus_out  (dbus),
        .ovf       (ovf),
        .unf       (unf),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_sp, m_lo, m_hi, m_hwm;
    bit m_ovf, m_unf, m_fault;

    task automatic model_step();
        int  d_in;
        int  delta;
        int  cand;
        int  new_sp;
        bit  upd;
        d_in   = int'(din);
        new_sp = m_sp;
        upd    = 1'b0;
        if (clr_flt) begin
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_fault = 1'b0;
        end else if (!m_fault) begin
            if (write) begin
                new_sp = d_in;
                upd    = 1'b1;
            end else if (adj || inc || dec) begin
                if (adj)      delta = (d_in >= 2**(W-1)) ? d_in - 2**W : d_in;
                else if (inc) delta = STEP;
                else          delta = -STEP;
                cand = m_sp + delta;
                if (cand >= m_lo && cand <= m_hi) begin
                    new_sp = cand;
                    upd    = 1'b1;
                end else begin
                    if (adj ? (delta >= 0) : inc) m_ovf = 1'b1;
                    else                          m_unf = 1'b1;
                    m_fault = 1'b1;
                end
            end
        end
        if (clr_hwm)                    m_hwm = new_sp;
        else if (upd && new_sp < m_hwm) m_hwm = new_sp;
        m_sp = new_sp;
        if (wr_lo) m_lo = d_in;
        if (wr_hi) m_hi = d_in;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sp    = int'(RSP);
            m_lo    = 0;
            m_hi    = 2**W - 1;
            m_hwm   = int'(RSP);
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_fault = 1'b0;
        end else begin
            model_step();
        end
    end

    // Compare DUT against the model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("ovf", ovf, m_ovf);
            check("unf", unf, m_unf);
            check("fault", fault, m_fault);
            if (read_abus) check("abus", abus, m_sp);
`ifdef SP_HWM_EN
            if (read_hwm)       check("dbus_hwm", dbus, m_hwm);
            else if (read_dbus) check("dbus", dbus, m_sp);
`else
            if (read_dbus) check("dbus", dbus, m_sp);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [W-1:0] d, input logic [7:0] ops);
        din     = d;
        write   = ops[0];
        adj     = ops[1];
        inc     = ops[2];
        dec     = ops[3];
        wr_lo   = ops[4];
        wr_hi   = ops[5];
        clr_flt = ops[6];
`ifdef SP_HWM_EN
        clr_hwm = ops[7];
`endif
        @(posedge clk);
        #2;
        {write, adj, inc, dec, wr_lo, wr_hi, clr_flt} = '0;
        clr_hwm = 1'b0;
    endtask

    initial begin
        logic [7:0]   ops;
        logic [W-1:0] d;
        int           r;

        reset = 1'b1;
        din = '0;
        {write, adj, inc, dec, wr_lo, wr_hi, clr_flt} = '0;
        read_abus = 1'b0;
        read_dbus = 1'b0;
        read_hwm  = 1'b0;
        clr_hwm   = 1'b0;

        // Reset state and high-Z buses.
        #1;
        check("rst_abus_hiz", abus, 16'hFFFF);
        check("rst_dbus_hiz", dbus, 16'hFFFF);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);
        check("rst_fault", fault, 0);
        read_abus = 1'b1;
        #1;
        check("rst_abus", abus, 16'h0000);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // write then two pushes; priority of write over inc/dec.
        cyc(16'h0100, OP_WR);
        cyc(16'h0000, OP_DEC);
        cyc(16'h0000, OP_DEC);
        check("dec2", abus, 16'h00FE);
        cyc(16'h1234, OP_WR | OP_INC | OP_DEC);
        check("write_prio", abus, 16'h1234);

        // Underflow at lower bound, lock-out, recovery.
        cyc(16'h00F0, OP_WR | OP_LO);
        cyc(16'h0000, OP_DEC);
        check("unf_sp", abus, 16'h00F0);
        check("unf_flag", unf, 1);
        check("unf_fault", fault, 1);
        cyc(16'h0000, OP_INC);
        check("fault_ignores_inc", abus, 16'h00F0);
        cyc(16'h0000, OP_CLR);
        check("clr_fault", fault, 0);
        check("clr_unf", unf, 0);
        cyc(16'h0000, OP_INC);
        check("inc_after_clr", abus, 16'h00F1);

        // Carry out of the top is rejected.
        cyc(16'hFFFF, OP_WR);
        cyc(16'h0000, OP_INC);
        check("carry_ovf", ovf, 1);
        check("carry_sp", abus, 16'hFFFF);
        cyc(16'h0000, OP_CLR);

        // Signed adjust, then adjust beyond upper bound.
        cyc(16'h0200, OP_WR);
        cyc(16'hFFF0, OP_ADJ);
        check("adj_neg", abus, 16'h01F0);
        cyc(16'h1000, OP_HI);
        cyc(16'h7000, OP_ADJ);
        check("adj_ovf", ovf, 1);
        check("adj_ovf_sp", abus, 16'h01F0);
        cyc(16'h0000, OP_CLR);

        // clr_flt swallows a same-cycle op; op sees the old bounds.
        cyc(16'h0000, OP_CLR | OP_INC);
        check("clr_swallows_inc", abus, 16'h01F0);
        cyc(16'h01F0, OP_HI | OP_INC);
        check("old_hi_used", abus, 16'h01F1);
        check("old_hi_nofault", fault, 0);
        cyc(16'h0000, OP_INC);
        check("new_hi_used", fault, 1);

        // Reset asserted mid-cycle while in FAULT.
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_fault", fault, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_sp", abus, 16'h0000);
        @(posedge clk);
        #2;
        reset = 1'b0;

`ifdef SP_HWM_EN
        // Low-water mark tracking.
        cyc(16'h0100, OP_WR | OP_CLRH);
        cyc(16'h0000, OP_DEC);
        cyc(16'h0000, OP_DEC);
        cyc(16'h0000, OP_DEC);
        cyc(16'h0000, OP_INC);
        cyc(16'h0000, OP_INC);
        read_hwm  = 1'b1;
        read_dbus = 1'b1;
        #1;
        check("hwm_min", dbus, 16'h00FD);
        cyc(16'h0000, OP_CLRH);
        check("hwm_clr", dbus, 16'h00FF);
        read_hwm  = 1'b0;
        read_dbus = 1'b0;
`endif

        // Randomized phase, checked by the compare process every cycle.
        cyc(16'h0100, OP_LO);
        cyc(16'hFF00, OP_HI);
        cyc(16'h8000, OP_WR);
        for (int n = 0; n < 3000; n++) begin
            ops = '0;
            r = int'($urandom_range(0, 99));
            if (r < 5)       ops |= OP_WR;
            else if (r < 30) ops |= OP_ADJ;
            else if (r < 62) ops |= OP_INC;
            else if (r < 94) ops |= OP_DEC;
            if ($urandom_range(0, 99) < 8)  ops |= OP_INC | OP_DEC;
            if ($urandom_range(0, 99) < 3)  ops |= OP_LO;
            if ($urandom_range(0, 99) < 3)  ops |= OP_HI;
            if ($urandom_range(0, 99) < (fault ? 30 : 3)) ops |= OP_CLR;
            if ($urandom_range(0, 99) < 4)  ops |= OP_CLRH;

            if (ops[4])                      d = (W)'($urandom_range(0, 16'h4000));
            else if (ops[5])                 d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : (W)'($urandom_range(16'h8000, 16'hFFFF));
            else if (ops[1] && $urandom_range(0, 3) != 0) d = (W)'($urandom_range(0, 256) - 128);
            else                             d = (W)'($urandom);

            read_abus = ($urandom_range(0, 3) != 0);
            read_dbus = $urandom_range(0, 1) == 1;
`ifdef SP_HWM_EN
            read_hwm  = $urandom_range(0, 2) == 0;
`endif
            cyc(d, ops);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_ptr_unit.md
Name: stack_ptr_unit

Overview:
- Parametrised stack-pointer register for the CPU datapath, with tri-state drivers onto the address and data buses.
- Generalises the plain push/pop pointer:
  - configurable width and step size
  - programmable lower/upper bound registers
  - signed frame adjust
  - sticky overflow/underflow detection with a FAULT lock-out state
- Sits beside the register file and is driven by the control unit on push/pop/call/ret/frame micro-ops.

Parameters:
- WIDTH, 16, bit width of the pointer, bounds and buses.
- STEP, 1, amount added by inc and subtracted by dec; must satisfy 1 <= STEP < 2^WIDTH.
- RESET_SP, 0, value loaded into the pointer on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  WIDTH  data bus input for load, adjust and bound writes.
- write  input  1  load pointer from din.
- adj  input  1  add din, as a signed two's-complement value, to the pointer.
- inc  input  1  pointer += STEP (pop).
- dec  input  1  pointer -= STEP (push).
- wr_lo  input  1  load lower bound from din.
- wr_hi  input  1  load upper bound from din.
- clr_flt  input  1  clear ovf/unf and leave FAULT.
- read_abus  input  1  drive pointer onto abus_out.
- read_dbus  input  1  drive pointer onto dbus_out.
- abus_out  output  WIDTH  pointer when read_abus=1, else high-Z.
- dbus_out  output  WIDTH  pointer when read_dbus=1, else high-Z.
- ovf  output  1  sticky: an inc or adj was rejected at the upper bound.
- unf  output  1  sticky: a dec or adj was rejected at the lower bound.
- fault  output  1  high while in the FAULT state.

Behaviour:
- Reset, asynchronous:
  - sp=RESET_SP, lo=0, hi=all ones.
  - ovf=0, unf=0; state=RUN, so fault=0.
  - Bus outputs depend only on the read strobes.
- Bus outputs are purely combinational.
  - read_abus and read_dbus are independent; both may be high together.
  - With SP_HWM_EN, see the data-bus override below.
- Bound writes:
  - wr_lo and wr_hi are accepted in any state and take effect next cycle.
  - They are independent of the pointer ops.
  - A bound write does not re-check the current sp.
- Pointer ops are accepted only in RUN. Priority when several are high: write > adj > inc > dec; lower-priority ops are ignored.
- write: sp <= din unconditionally, with no bounds check. This is the recovery path.
- Arithmetic for inc, dec and adj:
  - Candidate is computed in WIDTH+1 bits; adj sign-extends din.
  - Carry or borrow out of WIDTH bits is treated as out of range.
  - Acceptance condition: lo <= candidate <= hi, compared unsigned.
  - Accepted: sp <= candidate.
  - Rejected: sp is unchanged, the flag is set and state goes to FAULT on the same edge.
- Flag selection on rejection:
  - inc: sets ovf.
  - dec: sets unf.
  - adj: sets ovf if din is non-negative, else unf.
- adj with din=0 is always accepted when lo <= sp <= hi, and is a no-op.
- States:
  - RUN -> FAULT on any rejection.
  - FAULT -> RUN on clr_flt, which also clears ovf and unf.
  - In FAULT, write, adj, inc and dec are ignored; the bus reads still work.
  - clr_flt in RUN clears the flags and is otherwise a no-op.
- Same-cycle interactions:
  - clr_flt and a pointer op in the same cycle: clear takes effect; the op is ignored this cycle.
  - A bound write and a pointer op in the same cycle: the op checks the old bounds.
- Latency: one clock for every update; no multi-cycle ops.
- Reset asserted mid-sequence overrides everything immediately, including FAULT.

Optional Feature:
- Macro: SP_HWM_EN.
- When defined:
  - Adds a WIDTH-bit register hwm, reset to RESET_SP.
  - Every accepted pointer update, including write, sets hwm <= min(hwm, new sp). The stack grows downward.
  - Adds input read_hwm (1 bit). When read_hwm=1, dbus_out drives hwm and read_hwm has priority over read_dbus.
  - Adds input clr_hwm (1 bit), which sets hwm <= current sp. If it coincides with an accepted update, the new sp is used.
- When undefined: no hwm register and no read_hwm or clr_hwm ports; the behaviour is exactly as described above.

Test Plan:
- Reset with RESET_SP=0 -> sp=0x0000, ovf=unf=fault=0; with read_abus=1, abus_out=0x0000; with both strobes low, both buses are high-Z.
- write din=0x0100, then dec x2 (STEP=1) -> sp=0x00FE; inc, dec and write asserted together -> write wins, sp=din.
- wr_lo=0x00F0, sp=0x00F0, then dec -> sp stays 0x00F0, unf=1, fault=1; the next inc is ignored; clr_flt -> fault=0, unf=0; the following inc -> 0x00F1.
- wr_hi=0xFFFF, sp=0xFFFF, then inc -> carry is rejected, ovf=1, sp=0xFFFF.
- sp=0x0200 with adj din=0xFFF0 (-16) -> 0x01F0; adj din=0x7000 with hi=0x1000 -> rejected, ovf=1.
- SP_HWM_EN: write 0x0100, dec x3, inc x2 -> hwm=0x00FD; read_hwm and read_dbus high together -> dbus_out=0x00FD; clr_hwm -> hwm=0x00FF.
